// File: rtl/ave8_thresh.sv
// rtl/ave8_thresh.sv - hysteresis level detector sampling the ave8 output once per frame (optional AVE8_THRESH_PEAK_EN)
module ave8_thresh #(
    parameter logic [7:0] HI_TH  = 8'hC0,
    parameter logic [7:0] LO_TH  = 8'h40,
    parameter int         SETTLE = 8,
    parameter int         CNT_W  = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [7:0]       avg_in,
    input  logic             clr_cnt,
    output logic             det_level,
    output logic             det_rise,
    output logic             det_fall,
    output logic [CNT_W-1:0] event_cnt,
    output logic [7:0]       peak_val
);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_LOW    = 2'd1,
        ST_HIGH   = 2'd2
    } state_t;

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    // Illegal configurations are reported at elaboration, before any clock runs.
    if ((LO_TH >= HI_TH) || (SETTLE < 1) || (SETTLE > 255)) begin : g_bad_params
        $error("ave8_thresh: illegal parameters (need LO_TH < HI_TH and 1 <= SETTLE <= 255)");
    end

    state_t     state, state_nxt;
    logic [1:0] ph;
    logic [7:0] settle_cnt, settle_nxt;
    logic       smp;
    logic       rise_nxt, fall_nxt;

    // ph==0 lines up with the ave8 frame slot where a fresh average first appears.
    assign smp = (ph == 2'd0);

    // State register, frame phase and settle counter.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= ST_SETTLE;
            ph         <= 2'd0;
            settle_cnt <= 8'd0;
        end else begin
            state      <= state_nxt;
            ph         <= ph + 2'd1;
            settle_cnt <= settle_nxt;
        end
    end

    // Next-state logic; only strobe cycles can move the detector.
    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        if (smp) begin
            case (state)
                ST_SETTLE: begin
                    // The strobe that ends the settle window still discards its sample.
                    settle_nxt = settle_cnt + 8'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nxt = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (avg_in >= HI_TH) begin
                        state_nxt = ST_HIGH;
                        rise_nxt  = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (avg_in <= LO_TH) begin
                        state_nxt = ST_LOW;
                        fall_nxt  = 1'b1;
                    end
                end
                default: state_nxt = ST_SETTLE;
            endcase
        end
    end

    // Registered outputs and the saturating rise counter; clear beats increment.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            det_level <= 1'b0;
            det_rise  <= 1'b0;
            det_fall  <= 1'b0;
            event_cnt <= '0;
        end else begin
            det_level <= (state_nxt == ST_HIGH);
            det_rise  <= rise_nxt;
            det_fall  <= fall_nxt;
            if (clr_cnt) begin
                event_cnt <= '0;
            end else if (rise_nxt && (event_cnt != CNT_MAX)) begin
                event_cnt <= event_cnt + 1'b1;
            end
        end
    end

`ifdef AVE8_THRESH_PEAK_EN
    logic [7:0] peak_q;

    // Peak restarts at the rising sample and tracks the max while HIGH; holds through LOW.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            peak_q <= 8'h00;
        end else if (rise_nxt) begin
            peak_q <= avg_in;
        end else if (smp && (state == ST_HIGH) && (avg_in > peak_q)) begin
            peak_q <= avg_in;
        end
    end

    assign peak_val = peak_q;
`else
    assign peak_val = 8'h00;
`endif

endmodule

// File: tb/tb_ave8_thresh.sv
// tb/tb_ave8_thresh.sv - self-checking bench for ave8_thresh
module tb_ave8_thresh;

    localparam logic [7:0] HI     = 8'hC0;
    localparam logic [7:0] LO     = 8'h40;
    localparam int         SETTLE = 8;
`ifdef AVE8_THRESH_PEAK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  avg_in = 8'h00;
    logic        clr_cnt = 1'b0;
    logic        clr2 = 1'b0;
    logic        det_level, det_rise, det_fall;
    logic [15:0] event_cnt;
    logic [7:0]  peak_val;
    logic        lvl2, rise2, fall2;
    logic [1:0]  cnt2;
    logic [7:0]  peak2;

    always #5 CLOCK = ~CLOCK;

    ave8_thresh dut (
        .CLOCK(CLOCK), .RESET(RESET), .avg_in(avg_in), .clr_cnt(clr_cnt),
        .det_level(det_level), .det_rise(det_rise), .det_fall(det_fall),
        .event_cnt(event_cnt), .peak_val(peak_val)
    );

    ave8_thresh #(.CNT_W(2)) dut2 (
        .CLOCK(CLOCK), .RESET(RESET), .avg_in(avg_in), .clr_cnt(clr2),
        .det_level(lvl2), .det_rise(rise2), .det_fall(fall2),
        .event_cnt(cnt2), .peak_val(peak2)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: strobe index since reset decides what is evaluated.
    int m_cyc = 0;
    bit m_lvl, m_rise, m_fall;
    int m_cnt, m_cnt2, m_peak;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int a, input bit c, input bit c2, input bit r);
        if (r) begin
            m_cyc = 0; m_lvl = 0; m_rise = 0; m_fall = 0;
            m_cnt = 0; m_cnt2 = 0; m_peak = 0;
            return;
        end
        m_rise = 0;
        m_fall = 0;
        if ((m_cyc % 4 == 0) && (m_cyc / 4 >= SETTLE)) begin
            if (!m_lvl) begin
                if (a >= HI) begin
                    m_lvl = 1; m_rise = 1; m_peak = a;
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end else begin
                if (a > m_peak) m_peak = a;
                if (a <= LO) begin
                    m_lvl = 0; m_fall = 1;
                end
            end
        end
        if (c)  m_cnt = 0;
        if (c2) m_cnt2 = 0;
        m_cyc++;
    endtask

    task automatic tick(input logic [7:0] a, input bit c, input bit c2, input bit r);
        avg_in = a; clr_cnt = c; clr2 = c2; RESET = r;
        @(posedge CLOCK);
        model_step(a, c, c2, r);
        #1;
        chk("level", det_level, m_lvl);
        chk("rise", det_rise, m_rise);
        chk("fall", det_fall, m_fall);
        chk("event_cnt", event_cnt, m_cnt);
        chk("event_cnt_w2", cnt2, m_cnt2);
        chk("level_w2", lvl2, m_lvl);
        chk("peak_val", peak_val, PEAK_ON ? m_peak : 0);
    endtask

    // One full frame: strobe cycle first, outputs captured right after the strobe edge.
    task automatic strobe(input logic [7:0] a, input bit c, input bit c2,
                          output bit lv, output bit rs, output bit fl, output int cn, output int cn2);
        tick(a, c, c2, 1'b0);
        lv = det_level; rs = det_rise; fl = det_fall; cn = event_cnt; cn2 = cnt2;
        repeat (3) tick(a, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_settle(input logic [7:0] a);
        bit lv, rs, fl; int cn, cn2;
        tick(a, 1'b0, 1'b0, 1'b1);
        chk("reset_level", det_level, 0);
        chk("reset_cnt", event_cnt, 0);
        chk("reset_peak", peak_val, 0);
        for (int i = 0; i < SETTLE; i++) begin
            strobe(a, 1'b0, 1'b0, lv, rs, fl, cn, cn2);
            chk("settle_no_rise", rs, 0);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        bit         c;
        bit         lvl;
        bit         rise;
        bit         fall;
        int         cnt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        bit lv, rs, fl;
        int cn, cn2;
        int n_rise;

        tbl[0]  = '{8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{8'hC0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        tbl[2]  = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[3]  = '{8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[4]  = '{8'hBF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[5]  = '{8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[6]  = '{8'hC1, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        tbl[7]  = '{8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        tbl[8]  = '{8'hBF, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        tbl[9]  = '{8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        tbl[10] = '{8'hC1, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        tbl[11] = '{8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tbl[12] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 3};
        tbl[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3};
        tbl[14] = '{8'hC0, 1'b1, 1'b1, 1'b1, 1'b0, 0};

        // Constant 0xFF from reset: first rise visible in cycle 33.
        tick(8'hFF, 1'b0, 1'b0, 1'b1);
        n_rise = 0;
        for (int k = 0; k < 44; k++) begin
            tick(8'hFF, 1'b0, 1'b0, 1'b0);
            chk("t1_rise_timing", det_rise, (k == 32) ? 1 : 0);
            n_rise += det_rise;
        end
        chk("t1_rise_count", n_rise, 1);
        chk("t1_level", det_level, 1);
        chk("t1_cnt", event_cnt, 1);

        // Table: rise/hold/fall, hysteresis band, clear racing an increment.
        reset_settle(8'h00);
        for (int i = 0; i < 15; i++) begin
            strobe(tbl[i].a, tbl[i].c, 1'b0, lv, rs, fl, cn, cn2);
            chk("tbl_level", lv, tbl[i].lvl);
            chk("tbl_rise", rs, tbl[i].rise);
            chk("tbl_fall", fl, tbl[i].fall);
            chk("tbl_cnt", cn, tbl[i].cnt);
        end

        // 2-bit counter: clear on the 4th rise, then saturation at 3.
        reset_settle(8'h00);
        for (int i = 0; i < 4; i++) begin
            strobe(8'hFF, 1'b0, (i == 3), lv, rs, fl, cn, cn2);
            chk("t4_cnt2_clr", cn2, (i < 3) ? i + 1 : 0);
            strobe(8'h00, 1'b0, 1'b0, lv, rs, fl, cn, cn2);
        end
        for (int i = 0; i < 5; i++) begin
            strobe(8'hFF, 1'b0, 1'b0, lv, rs, fl, cn, cn2);
            chk("t4_cnt2_sat", cn2, (i < 3) ? i + 1 : 3);
            strobe(8'h00, 1'b0, 1'b0, lv, rs, fl, cn, cn2);
        end

        // Peak tracking through a high episode and hold after the fall.
        reset_settle(8'h00);
        strobe(8'hC8, 1'b0, 1'b0, lv, rs, fl, cn, cn2);
        chk("t5_peak_c8", peak_val, PEAK_ON ? 8'hC8 : 0);
        strobe(8'hF0, 1'b0, 1'b0, lv, rs, fl, cn, cn2);
        chk("t5_peak_f0", peak_val, PEAK_ON ? 8'hF0 : 0);
        strobe(8'hD0, 1'b0, 1'b0, lv, rs, fl, cn, cn2);
        chk("t5_peak_d0", peak_val, PEAK_ON ? 8'hF0 : 0);
        strobe(8'h30, 1'b0, 1'b0, lv, rs, fl, cn, cn2);
        chk("t5_fall", fl, 1);
        strobe(8'h80, 1'b0, 1'b0, lv, rs, fl, cn, cn2);
        chk("t5_peak_hold", peak_val, PEAK_ON ? 8'hF0 : 0);

        // Reset while HIGH restarts the whole settle window.
        reset_settle(8'hFF);
        strobe(8'hFF, 1'b0, 1'b0, lv, rs, fl, cn, cn2);
        chk("t6_first_rise", rs, 1);
        tick(8'hFF, 1'b0, 1'b0, 1'b1);
        chk("t6_level_cleared", det_level, 0);
        chk("t6_cnt_cleared", event_cnt, 0);
        for (int i = 0; i < SETTLE; i++) begin
            strobe(8'hFF, 1'b0, 1'b0, lv, rs, fl, cn, cn2);
            chk("t6_settle_no_rise", rs, 0);
        end
        strobe(8'hFF, 1'b0, 1'b0, lv, rs, fl, cn, cn2);
        chk("t6_rise_after_settle", rs, 1);

        // Random traffic around both thresholds, checked every cycle by the model.
        tick(8'h00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] a;
            case ($urandom_range(0, 2))
                0:       a = 8'($urandom_range(0, 255));
                1:       a = 8'($urandom_range(8'hBD, 8'hC3));
                default: a = 8'($urandom_range(8'h3D, 8'h43));
            endcase
            tick(a, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 399) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
